// File: rtl/say_arbiter.sv
// Two-requester round-robin arbiter with a one-entry holding buffer per requester,
// delivering {v, meth} messages downstream and keeping grant/contention statistics.
module say_arbiter (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       req0_say__ENA,
  input  logic [5:0] req0_say_meth,
  input  logic [3:0] req0_say_v,
  output logic       req0_say__RDY,
  input  logic       req1_say__ENA,
  input  logic [5:0] req1_say_meth,
  input  logic [3:0] req1_say_v,
  output logic       req1_say__RDY,
  output logic       ind_heard__ENA,
  output logic [5:0] ind_heard_meth,
  output logic [3:0] ind_heard_v,
  input  logic       ind_heard__RDY,
  output logic [8:0] stat_grants0,
  output logic [8:0] stat_grants1,
  output logic [8:0] stat_contend
);

  localparam logic [8:0] CONTEND_MAX = 9'h1FF;

  logic       r_valid0;
  logic       r_valid1;
  logic [9:0] r_pay0;
  logic [9:0] r_pay1;
  logic       r_ptr;
  logic [8:0] r_grants0;
  logic [8:0] r_grants1;
  logic [8:0] r_contend;

  logic       w_any;
  logic       w_both;
  logic       w_sel1;
  logic       w_fire;
  logic       w_grant0;
  logic       w_grant1;
  logic       w_rdy0;
  logic       w_rdy1;
  logic       w_cap0;
  logic       w_cap1;
  logic [9:0] w_pay_sel;

  assign w_any  = r_valid0 | r_valid1;
  assign w_both = r_valid0 & r_valid1;

  // Buffer 1 wins when it is the only one valid, or when both are valid and ptr points at it.
  assign w_sel1 = r_valid1 & (~r_valid0 | r_ptr);
  assign w_fire = w_any & ind_heard__RDY;

  assign w_grant0 = w_fire & ~w_sel1;
  assign w_grant1 = w_fire &  w_sel1;

  assign w_rdy0 = ~r_valid0 | w_grant0;
  assign w_rdy1 = ~r_valid1 | w_grant1;
  assign w_cap0 = req0_say__ENA & w_rdy0;
  assign w_cap1 = req1_say__ENA & w_rdy1;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    w_pay_sel = r_pay0;
    if (w_sel1) begin
      w_pay_sel = r_pay1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_valid0  <= 1'b0;
      r_valid1  <= 1'b0;
      r_ptr     <= 1'b0;
      r_grants0 <= 9'd0;
      r_grants1 <= 9'd0;
      r_contend <= 9'd0;
    end else begin
      if (w_cap0) begin
        r_valid0 <= 1'b1;
      end else if (w_grant0) begin
        r_valid0 <= 1'b0;
      end

      if (w_cap1) begin
        r_valid1 <= 1'b1;
      end else if (w_grant1) begin
        r_valid1 <= 1'b0;
      end

      if (w_grant0) begin
        r_ptr <= 1'b1;
      end else if (w_grant1) begin
        r_ptr <= 1'b0;
      end

      if (w_grant0) begin
        r_grants0 <= r_grants0 + 9'd1;
      end
      if (w_grant1) begin
        r_grants1 <= r_grants1 + 9'd1;
      end

      // Contention is counted on stalled cycles too; the counter sticks at its maximum.
      if (w_both && (r_contend != CONTEND_MAX)) begin
        r_contend <= r_contend + 9'd1;
      end
    end
  end

  // NOTE: payload storage is deliberately not reset; it is qualified by the valid bits.
  always_ff @(posedge CLK) begin
    if (w_cap0) begin
      r_pay0 <= {req0_say_v, req0_say_meth};
    end
    if (w_cap1) begin
      r_pay1 <= {req1_say_v, req1_say_meth};
    end
  end

  assign req0_say__RDY  = w_rdy0;
  assign req1_say__RDY  = w_rdy1;
  assign ind_heard__ENA = w_fire;
  assign ind_heard_meth = w_pay_sel[5:0];
  assign ind_heard_v    = w_pay_sel[9:6];
  assign stat_grants0   = r_grants0;
  assign stat_grants1   = r_grants1;
  assign stat_contend   = r_contend;

endmodule

// File: tb/tb_say_arbiter.sv
// Self-checking bench for say_arbiter: directed scenarios with fixed expectations plus
// randomized traffic compared against a queue-based behavioural model.
module tb_say_arbiter;

  logic       CLK = 1'b0;
  logic       nrst;
  logic       e0, e1, hr;
  logic [5:0] m0, m1;
  logic [3:0] v0, v1;
  logic       rdy0, rdy1, hena;
  logic [5:0] hmeth;
  logic [3:0] hv;
  logic [8:0] g0, g1, ct;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  say_arbiter dut (
    .CLK            (CLK),
    .nRST           (nrst),
    .req0_say__ENA  (e0),
    .req0_say_meth  (m0),
    .req0_say_v     (v0),
    .req0_say__RDY  (rdy0),
    .req1_say__ENA  (e1),
    .req1_say_meth  (m1),
    .req1_say_v     (v1),
    .req1_say__RDY  (rdy1),
    .ind_heard__ENA (hena),
    .ind_heard_meth (hmeth),
    .ind_heard_v    (hv),
    .ind_heard__RDY (hr),
    .stat_grants0   (g0),
    .stat_grants1   (g1),
    .stat_contend   (ct)
  );

  // Behavioural model: each buffer is a queue holding at most one message.
  logic [9:0] mq0[$];
  logic [9:0] mq1[$];
  int m_ptr = 0, m_g0 = 0, m_g1 = 0, m_ct = 0;

  function automatic void model_expect(output bit x_ena, output bit x_rdy0, output bit x_rdy1,
                                       output logic [9:0] x_pay, output int x_sel);
    bit f0, f1;
    f0 = (mq0.size() != 0);
    f1 = (mq1.size() != 0);
    x_sel  = (f0 && f1) ? m_ptr : (f1 ? 1 : 0);
    x_ena  = (f0 || f1) && hr;
    x_pay  = (x_sel == 1) ? (f1 ? mq1[0] : 10'h0) : (f0 ? mq0[0] : 10'h0);
    x_rdy0 = !f0 || (x_ena && x_sel == 0);
    x_rdy1 = !f1 || (x_ena && x_sel == 1);
  endfunction

  always @(posedge CLK) begin : model
    bit x_ena, x_rdy0, x_rdy1;
    logic [9:0] x_pay;
    int x_sel;
    if (!nrst) begin
      mq0.delete();
      mq1.delete();
      m_ptr = 0; m_g0 = 0; m_g1 = 0; m_ct = 0;
    end else begin
      model_expect(x_ena, x_rdy0, x_rdy1, x_pay, x_sel);
      if (mq0.size() != 0 && mq1.size() != 0 && m_ct < 511) m_ct++;
      if (x_ena && x_sel == 0) begin
        void'(mq0.pop_front());
        m_g0 = (m_g0 + 1) % 512;
        m_ptr = 1;
      end
      if (x_ena && x_sel == 1) begin
        void'(mq1.pop_front());
        m_g1 = (m_g1 + 1) % 512;
        m_ptr = 0;
      end
      if (e0 && x_rdy0) mq0.push_back({v0, m0});
      if (e1 && x_rdy1) mq1.push_back({v1, m1});
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    e0 = 1'b0;
    e1 = 1'b0;
  endtask

  task automatic reset_dut();
    nrst = 1'b0;
    idle();
    hr = 1'b1;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge CLK);
    checks++; if (hena !== 1'b0) begin errors++; $display("FAIL reset_ena: got %b expected 0", hena); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_rdy0: got %b expected 1", rdy0); end
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_rdy1: got %b expected 1", rdy1); end
    checks++; if ({g0, g1, ct} !== 27'd0) begin
      errors++; $display("FAIL reset_stats: got g0=%0d g1=%0d ct=%0d expected 0/0/0", g0, g1, ct);
    end
    tick();
  endtask

  task automatic test_single();
    reset_dut();
    e0 = 1'b1; m0 = 6'h2A; v0 = 4'h5; hr = 1'b1;
    @(negedge CLK);
    checks++; if (hena !== 1'b0) begin errors++; $display("FAIL single_early_ena: got %b expected 0", hena); end
    tick();
    idle();
    @(negedge CLK);
    checks++; if (hena !== 1'b1 || hmeth !== 6'h2A || hv !== 4'h5) begin
      errors++; $display("FAIL single_deliver: got ena=%b meth=%h v=%h expected 1/2a/5", hena, hmeth, hv);
    end
    tick();
    @(negedge CLK);
    checks++; if (g0 !== 9'd1 || hena !== 1'b0) begin
      errors++; $display("FAIL single_count: got g0=%0d ena=%b expected 1/0", g0, hena);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [5:0] exp_m;
    reset_dut();
    for (int k = 0; k <= 6; k++) begin
      e0 = 1'b1; m0 = 6'd1; v0 = 4'h1;
      e1 = 1'b1; m1 = 6'd2; v1 = 4'h2;
      hr = 1'b1;
      @(negedge CLK);
      if (k >= 1) begin
        exp_m = (k % 2 == 1) ? 6'd1 : 6'd2;
        checks++; if (hena !== 1'b1 || hmeth !== exp_m) begin
          errors++; $display("FAIL contend_order[%0d]: got ena=%b meth=%0d expected 1/%0d", k, hena, hmeth, exp_m);
        end
        checks++; if (rdy0 !== (k % 2 == 1) || rdy1 !== (k % 2 == 0)) begin
          errors++; $display("FAIL contend_rdy[%0d]: got %b%b expected %b%b", k, rdy0, rdy1, (k % 2 == 1), (k % 2 == 0));
        end
        checks++; if (ct !== 9'(k - 1)) begin
          errors++; $display("FAIL contend_count[%0d]: got %0d expected %0d", k, ct, k - 1);
        end
      end
      tick();
    end
    idle();
    @(negedge CLK);
    checks++; if (g0 !== 9'd3 || g1 !== 9'd3) begin
      errors++; $display("FAIL contend_grants: got %0d/%0d expected 3/3", g0, g1);
    end
    repeat (3) tick();
  endtask

  task automatic test_backpressure();
    reset_dut();
    // One lone req0 delivery moves ptr to 1 before the stall.
    e0 = 1'b1; m0 = 6'h05; v0 = 4'h0; hr = 1'b1;
    tick();
    idle();
    tick();
    e0 = 1'b1; m0 = 6'h11; v0 = 4'h3;
    e1 = 1'b1; m1 = 6'h22; v1 = 4'hC;
    hr = 1'b0;
    tick();
    idle();
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      checks++; if (hena !== 1'b0 || rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
        errors++; $display("FAIL stall[%0d]: got ena=%b rdy=%b%b expected 0/00", k, hena, rdy0, rdy1);
      end
      tick();
    end
    hr = 1'b1;
    @(negedge CLK);
    checks++; if (ct !== 9'd5) begin errors++; $display("FAIL stall_contend: got %0d expected 5", ct); end
    checks++; if (hena !== 1'b1 || hmeth !== 6'h22 || hv !== 4'hC) begin
      errors++; $display("FAIL stall_drain_first: got ena=%b meth=%h v=%h expected 1/22/c", hena, hmeth, hv);
    end
    tick();
    @(negedge CLK);
    checks++; if (hena !== 1'b1 || hmeth !== 6'h11 || hv !== 4'h3) begin
      errors++; $display("FAIL stall_drain_second: got ena=%b meth=%h v=%h expected 1/11/3", hena, hmeth, hv);
    end
    tick();
    @(negedge CLK);
    checks++; if (hena !== 1'b0 || g0 !== 9'd2 || g1 !== 9'd1 || ct !== 9'd6) begin
      errors++; $display("FAIL stall_final: got ena=%b g0=%0d g1=%0d ct=%0d expected 0/2/1/6", hena, g0, g1, ct);
    end
    tick();
  endtask

  task automatic test_streaming();
    reset_dut();
    hr = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      if (k < 20) begin
        e1 = 1'b1; m1 = 6'(k); v1 = 4'(k);
      end else begin
        e1 = 1'b0;
      end
      @(negedge CLK);
      if (k < 20) begin
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL stream_rdy[%0d]: got %b expected 1", k, rdy1); end
      end
      if (k >= 1) begin
        checks++; if (hena !== 1'b1 || hmeth !== 6'(k - 1) || hv !== 4'(k - 1)) begin
          errors++; $display("FAIL stream_data[%0d]: got ena=%b meth=%0d v=%0d expected 1/%0d/%0d",
                             k, hena, hmeth, hv, k - 1, (k - 1) % 16);
        end
      end
      tick();
    end
    @(negedge CLK);
    checks++; if (hena !== 1'b0 || g1 !== 9'd20) begin
      errors++; $display("FAIL stream_count: got ena=%b g1=%0d expected 0/20", hena, g1);
    end
    tick();
  endtask

  task automatic test_wrap_saturate();
    reset_dut();
    hr = 1'b1;
    for (int k = 0; k <= 512; k++) begin
      e0 = (k < 512); m0 = 6'(k); v0 = 4'(k);
      @(negedge CLK);
      if (k == 512) begin
        checks++; if (g0 !== 9'd511) begin errors++; $display("FAIL wrap_pre: got %0d expected 511", g0); end
      end
      tick();
    end
    idle();
    @(negedge CLK);
    checks++; if (g0 !== 9'd0) begin errors++; $display("FAIL wrap: got %0d expected 0", g0); end
    tick();

    reset_dut();
    for (int k = 0; k <= 600; k++) begin
      e0 = 1'b1; e1 = 1'b1;
      @(negedge CLK);
      if (k == 300 || k == 511 || k == 512) begin
        checks++; if (ct !== 9'(k - 1 > 511 ? 511 : k - 1)) begin
          errors++; $display("FAIL saturate[%0d]: got %0d expected %0d", k, ct, (k - 1 > 511) ? 511 : k - 1);
        end
      end
      tick();
    end
    idle();
    @(negedge CLK);
    checks++; if (ct !== 9'd511) begin errors++; $display("FAIL saturate_hold: got %0d expected 511", ct); end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    e0 = 1'b1; m0 = 6'h01; v0 = 4'h1; hr = 1'b1;
    tick();
    idle();
    tick();
    e0 = 1'b1; m0 = 6'h33; v0 = 4'h7;
    e1 = 1'b1; m1 = 6'h34; v1 = 4'h8;
    hr = 1'b0;
    tick();
    idle();
    tick();
    nrst = 1'b0;
    hr = 1'b1;
    tick();
    nrst = 1'b1;
    @(negedge CLK);
    checks++; if (hena !== 1'b0 || rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      errors++; $display("FAIL midreset_out: got ena=%b rdy=%b%b expected 0/11", hena, rdy0, rdy1);
    end
    checks++; if (g0 !== 9'd0 || g1 !== 9'd0 || ct !== 9'd0) begin
      errors++; $display("FAIL midreset_stats: got g0=%0d g1=%0d ct=%0d expected 0/0/0", g0, g1, ct);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge CLK);
      checks++; if (hena !== 1'b0) begin errors++; $display("FAIL midreset_stale[%0d]: got ena=%b expected 0", k, hena); end
    end
    tick();
  endtask

  task automatic test_random();
    bit x_ena, x_rdy0, x_rdy1;
    logic [9:0] x_pay;
    int x_sel;
    reset_dut();
    for (int k = 0; k < 3000; k++) begin
      nrst = ($urandom_range(0, 199) != 0);
      e0 = 1'($urandom_range(0, 1));
      e1 = 1'($urandom_range(0, 1));
      hr = ($urandom_range(0, 3) != 0);
      m0 = 6'($urandom); v0 = 4'($urandom);
      m1 = 6'($urandom); v1 = 4'($urandom);
      @(negedge CLK);
      model_expect(x_ena, x_rdy0, x_rdy1, x_pay, x_sel);
      checks++; if (hena !== x_ena || rdy0 !== x_rdy0 || rdy1 !== x_rdy1) begin
        errors++; $display("FAIL rand_ctrl[%0d]: got ena=%b rdy=%b%b expected %b/%b%b", k, hena, rdy0, rdy1, x_ena, x_rdy0, x_rdy1);
      end
      if (x_ena) begin
        checks++; if ({hv, hmeth} !== x_pay) begin
          errors++; $display("FAIL rand_data[%0d]: got %h expected %h", k, {hv, hmeth}, x_pay);
        end
      end
      checks++; if (g0 !== 9'(m_g0) || g1 !== 9'(m_g1) || ct !== 9'(m_ct)) begin
        errors++; $display("FAIL rand_stats[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", k, g0, g1, ct, m_g0, m_g1, m_ct);
      end
      tick();
    end
    nrst = 1'b1;
    idle();
  endtask

  initial begin
    nrst = 1'b0;
    e0 = 1'b0; e1 = 1'b0; hr = 1'b1;
    m0 = 6'h0; m1 = 6'h0; v0 = 4'h0; v1 = 4'h0;
    #1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_streaming();
    test_wrap_saturate();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
